// File: rtl/adc_id_checker_pkg.sv
// Shared constants and state encoding for the ADC-ID tagged fiber link.
// The ID tagger on the transmit side imports the same constants.
package adc_id_checker_pkg;

   localparam logic [15:0] HEADER_WORD  = 16'hAAAA;
   localparam logic [7:0]  IDLE_ID_MARK = 8'hB3;
   localparam int          NCH_DEFAULT  = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DATA  = 2'd1,
      TRAIL = 2'd2
   } state_t;

endpackage

// File: rtl/adc_id_checker_sat_counter.sv
// Saturating up-counter: holds at all-ones once full, cleared synchronously.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         i_clr,
   input  logic         i_inc,
   output logic [W-1:0] o_cnt
);

   logic [W-1:0] r_cnt;

   // Count increments until full, then hold; clear wins over increment.
   always_ff @(posedge clk) begin
      if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != '1)) begin
         r_cnt <= r_cnt + {{(W-1){1'b0}}, 1'b1};
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/adc_id_checker.sv
// Receive-side checker for the ADC-ID tagged fiber stream: locks on a
// header, verifies the ID of each payload word, demultiplexes payload to a
// channel index and reports per-frame status plus a running error count.
//
// state | meaning
// IDLE  | waiting for HEADER tagged with the idle ID
// DATA  | payload words, cnt = channel index of the current word
// TRAIL | trailer word, must carry the idle ID; frame status reported
module adc_id_checker
   import adc_id_checker_pkg::*;
#(
   parameter logic [15:0] HEADER  = HEADER_WORD,
   parameter logic [7:0]  IDLE_ID = IDLE_ID_MARK,
   parameter int          NCH     = NCH_DEFAULT,
   parameter int          ERR_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [15:0]      fiber_in,
   input  logic [7:0]       id_in,
   input  logic [7:0]       base_id,
   output logic [15:0]      data_out,
   output logic [3:0]       ch_out,
   output logic             data_valid,
   output logic             id_err,
   output logic             frame_done,
   output logic             frame_ok,
   output logic [ERR_W-1:0] err_cnt
);

   localparam logic [3:0] LAST_CH = 4'(NCH - 1);

   state_t     r_state;
   logic [3:0] r_cnt;
   logic [7:0] r_base;
   logic       r_bad;

   logic [7:0] w_exp_id;
   logic       w_is_hdr;
   logic       w_id_err;

   assign w_exp_id = r_base + {4'd0, r_cnt};
   assign w_is_hdr = (fiber_in == HEADER);

   // ID check for the word currently on the lane; also feeds the error counter
   // so err_cnt moves in the same cycle id_err is presented.
   always_comb begin
      w_id_err = 1'b0;
      case (r_state)
         IDLE:    w_id_err = w_is_hdr && (id_in != IDLE_ID);
         DATA:    w_id_err = (id_in != w_exp_id);
         TRAIL:   w_id_err = (id_in != IDLE_ID);
         default: w_id_err = 1'b0;
      endcase
   end

   // Frame FSM with registered outputs; a bad payload ID never breaks
   // alignment, so cnt advances regardless of the check result.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_cnt      <= 4'd0;
         r_base     <= 8'd0;
         r_bad      <= 1'b0;
         data_out   <= 16'd0;
         ch_out     <= 4'd0;
         data_valid <= 1'b0;
         id_err     <= 1'b0;
         frame_done <= 1'b0;
         frame_ok   <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         frame_done <= 1'b0;
         frame_ok   <= 1'b0;
         id_err     <= w_id_err;
         case (r_state)
            IDLE: begin
               if (w_is_hdr && (id_in == IDLE_ID)) begin
                  r_base  <= base_id;
                  r_cnt   <= 4'd0;
                  r_bad   <= 1'b0;
                  r_state <= DATA;
               end
            end
            DATA: begin
               data_out   <= fiber_in;
               ch_out     <= r_cnt;
               data_valid <= 1'b1;
               if (w_id_err) r_bad <= 1'b1;
               if (r_cnt == LAST_CH) begin
                  r_state <= TRAIL;
               end else begin
                  r_cnt <= r_cnt + 4'd1;
               end
            end
            TRAIL: begin
               frame_done <= 1'b1;
               frame_ok   <= !(r_bad || w_id_err);
               r_state    <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   sat_counter #(.W(ERR_W)) u_err_cnt (
      .clk   (clk),
      .i_clr (rst),
      .i_inc (w_id_err),
      .o_cnt (err_cnt)
   );

endmodule

// File: tb/tb_adc_id_checker.sv
// Directed bench for adc_id_checker: clean/corrupt/wrapping frames, embedded
// header, bad header, reset mid-frame, trailer acceptance rules and
// error-counter saturation (second instance with a 2-bit counter).
module tb_adc_id_checker;

   localparam logic [15:0] HDR = 16'hAAAA;
   localparam logic [7:0]  IID = 8'hB3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] fiber_in = 16'h0000;
   logic [7:0]  id_in = IID;
   logic [7:0]  base_id = 8'h00;

   logic [15:0] data_out;
   logic [3:0]  ch_out;
   logic        data_valid, id_err, frame_done, frame_ok;
   logic [15:0] err_cnt;

   logic [15:0] s_data_out;
   logic [3:0]  s_ch_out;
   logic        s_data_valid, s_id_err, s_frame_done, s_frame_ok;
   logic [1:0]  s_err_cnt;

   int n_checks = 0;
   int n_errors = 0;
   int exp_err  = 0;

   always #5 clk = ~clk;

   adc_id_checker dut (
      .clk(clk), .rst(rst), .fiber_in(fiber_in), .id_in(id_in), .base_id(base_id),
      .data_out(data_out), .ch_out(ch_out), .data_valid(data_valid), .id_err(id_err),
      .frame_done(frame_done), .frame_ok(frame_ok), .err_cnt(err_cnt)
   );

   adc_id_checker #(.ERR_W(2)) dut_sat (
      .clk(clk), .rst(rst), .fiber_in(fiber_in), .id_in(id_in), .base_id(base_id),
      .data_out(s_data_out), .ch_out(s_ch_out), .data_valid(s_data_valid), .id_err(s_id_err),
      .frame_done(s_frame_done), .frame_ok(s_frame_ok), .err_cnt(s_err_cnt)
   );

   // Present one word, let it be clocked in, observe the registered response.
   task automatic send(input logic [15:0] f, input logic [7:0] id);
      fiber_in = f;
      id_in    = id;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      send(16'h1234, 8'h00);
      send(16'h0000, IID);
      rst = 1'b0;
      exp_err = 0;
      n_checks++;
      if (data_valid !== 1'b0 || id_err !== 1'b0 || frame_done !== 1'b0 || frame_ok !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_flags: dv=%b ie=%b fd=%b fo=%b required 0000", data_valid, id_err, frame_done, frame_ok);
      end
      n_checks++;
      if (data_out !== 16'h0 || ch_out !== 4'h0 || err_cnt !== 16'h0) begin
         n_errors++;
         $display("FAIL reset_regs: data=%h ch=%h err=%h required 0", data_out, ch_out, err_cnt);
      end
   endtask

   // Full frame with base b, optional corrupt channel bad_ch (-1 = none),
   // optional payload override at hdr_ch with the header word.
   task automatic test_frame(input string nm, input logic [7:0] b, input int bad_ch, input int hdr_ch);
      logic [7:0]  id;
      logic [15:0] w;
      int fd_cnt;
      base_id = b;
      send(16'h0000, IID);
      send(HDR, IID);
      n_checks++;
      if (data_valid !== 1'b0 || id_err !== 1'b0) begin
         n_errors++;
         $display("FAIL %s_hdr: dv=%b ie=%b required 0 0", nm, data_valid, id_err);
      end
      base_id = b ^ 8'h5A;
      for (int i = 0; i < 16; i++) begin
         id = b + 8'(i);
         if (i == bad_ch) id = 8'h00;
         w = (i == hdr_ch) ? HDR : (16'hC000 + 16'(i));
         send(w, id);
         n_checks++;
         if (data_valid !== 1'b1 || ch_out !== 4'(i) || data_out !== w || id_err !== (i == bad_ch)) begin
            n_errors++;
            $display("FAIL %s_ch%0d: dv=%b ch=%0d data=%h ie=%b required 1 %0d %h %b",
                     nm, i, data_valid, ch_out, data_out, id_err, i, w, (i == bad_ch));
         end
         if (frame_done !== 1'b0) begin
            n_errors++;
            $display("FAIL %s_early_done: frame_done=%b at ch%0d required 0", nm, frame_done, i);
         end
      end
      if (bad_ch >= 0) exp_err++;
      send(16'h5555, IID);
      n_checks++;
      if (frame_done !== 1'b1 || frame_ok !== (bad_ch < 0) || data_valid !== 1'b0 ||
          err_cnt !== 16'(exp_err)) begin
         n_errors++;
         $display("FAIL %s_trailer: fd=%b fo=%b dv=%b err=%0d required 1 %b 0 %0d",
                  nm, frame_done, frame_ok, data_valid, err_cnt, (bad_ch < 0), exp_err);
      end
      fd_cnt = 0;
      for (int i = 0; i < 3; i++) begin
         send(16'h0001, IID);
         if (frame_done === 1'b1 || data_valid === 1'b1) fd_cnt++;
      end
      n_checks++;
      if (fd_cnt != 0) begin
         n_errors++;
         $display("FAIL %s_after: %0d stray done/valid cycles required 0", nm, fd_cnt);
      end
   endtask

   task automatic test_bad_header();
      send(16'h0000, IID);
      send(HDR, 8'h00);
      exp_err++;
      n_checks++;
      if (id_err !== 1'b1 || err_cnt !== 16'(exp_err)) begin
         n_errors++;
         $display("FAIL bad_header: ie=%b err=%0d required 1 %0d", id_err, err_cnt, exp_err);
      end
      send(16'h1111, 8'h00);
      n_checks++;
      if (data_valid !== 1'b0 || id_err !== 1'b0) begin
         n_errors++;
         $display("FAIL bad_header_stay_idle: dv=%b ie=%b required 0 0", data_valid, id_err);
      end
   endtask

   task automatic test_reset_mid_frame();
      int bad;
      base_id = 8'h40;
      send(HDR, IID);
      for (int i = 0; i < 8; i++) send(16'h2000 + 16'(i), 8'h40 + 8'(i));
      rst = 1'b1;
      send(16'h2008, 8'h48);
      rst = 1'b0;
      exp_err = 0;
      n_checks++;
      if (data_valid !== 1'b0 || frame_done !== 1'b0 || err_cnt !== 16'h0) begin
         n_errors++;
         $display("FAIL rst_mid: dv=%b fd=%b err=%0d required 0 0 0", data_valid, frame_done, err_cnt);
      end
      bad = 0;
      for (int i = 9; i < 18; i++) begin
         send(16'h2000 + 16'(i), 8'h40 + 8'(i));
         if (data_valid === 1'b1 || frame_done === 1'b1 || id_err === 1'b1) bad++;
      end
      n_checks++;
      if (bad != 0) begin
         n_errors++;
         $display("FAIL rst_mid_tail: %0d active cycles required 0", bad);
      end
   endtask

   // Header immediately in the trailer slot must not open a new frame.
   task automatic test_back_to_back();
      base_id = 8'h00;
      send(HDR, IID);
      for (int i = 0; i < 16; i++) send(16'h3000 + 16'(i), 8'(i));
      send(HDR, IID);
      n_checks++;
      if (frame_done !== 1'b1 || frame_ok !== 1'b1) begin
         n_errors++;
         $display("FAIL b2b_trailer: fd=%b fo=%b required 1 1", frame_done, frame_ok);
      end
      send(16'h3100, 8'h00);
      n_checks++;
      if (data_valid !== 1'b0 || id_err !== 1'b0) begin
         n_errors++;
         $display("FAIL b2b_no_resync: dv=%b ie=%b required 0 0", data_valid, id_err);
      end
      send(16'h0000, IID);
   endtask

   task automatic test_bad_trailer();
      base_id = 8'h20;
      send(HDR, IID);
      for (int i = 0; i < 16; i++) send(16'h4000 + 16'(i), 8'h20 + 8'(i));
      send(16'h5555, 8'h00);
      exp_err++;
      n_checks++;
      if (frame_done !== 1'b1 || frame_ok !== 1'b0 || id_err !== 1'b1 || err_cnt !== 16'(exp_err)) begin
         n_errors++;
         $display("FAIL bad_trailer: fd=%b fo=%b ie=%b err=%0d required 1 0 1 %0d",
                  frame_done, frame_ok, id_err, err_cnt, exp_err);
      end
      send(16'h0000, IID);
   endtask

   task automatic test_saturation();
      logic [1:0] exp_s;
      rst = 1'b1;
      send(16'h0000, IID);
      rst = 1'b0;
      exp_err = 0;
      for (int k = 1; k <= 5; k++) begin
         send(HDR, 8'h00);
         exp_err++;
         exp_s = (k >= 3) ? 2'b11 : 2'(k);
         n_checks++;
         if (s_err_cnt !== exp_s || err_cnt !== 16'(exp_err)) begin
            n_errors++;
            $display("FAIL sat_%0d: sat_err=%b err=%0d required %b %0d", k, s_err_cnt, err_cnt, exp_s, exp_err);
         end
      end
   endtask

   initial begin
      test_reset();
      test_frame("clean", 8'h10, -1, -1);
      test_frame("wrong_id", 8'h10, 5, -1);
      test_frame("wrap", 8'hF8, -1, -1);
      test_frame("embedded_hdr", 8'h33, -1, 3);
      test_bad_header();
      test_bad_trailer();
      test_reset_mid_frame();
      test_frame("after_rst", 8'h10, -1, -1);
      test_back_to_back();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
